// File: rtl/r88_int_sequencer.sv
// r88_int_sequencer: arbitrates reset/NMI/IRQ requests and sequences interrupt entry into the decoder
// Define R88_INT_SYNC_EN to pass resetReq, nmiReq and irq through 2-flop synchronizers (+2 cycles latency).
module r88_int_sequencer #(
    parameter logic [15:0] RESET_VEC = 16'hFFFC,
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
    input logic sysClock,
    input logic sysReset,
    input logic resetReq,
    input logic nmiReq,
    input logic irq,
    input logic irqEn,
    input logic instBoundary,
    input logic stepDone,
    output logic intActive,
    output logic stepReq,
    output logic [2:0] stepOp,
    output logic [15:0] stepAddr,
    output logic [1:0] intType,
    output logic setIrqDis
);
    typedef enum logic [2:0] {IDLE, ARM, PCH, PCL, FLG, VLO, VHI, DONE} state_t;
    state_t state;
    logic reset_in, nmi_in, irq_in;
    logic nmi_prev, nmi_pend, por_pend;
    logic nmi_edge, reset_q, nmi_q, irq_q, abort;
    logic [1:0] winner;
`ifdef R88_INT_SYNC_EN
    logic [2:0] sync1, sync2;
    // two-flop synchronizers for the asynchronous request pins
    always_ff @(posedge sysClock) begin
        if (sysReset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {resetReq, nmiReq, irq};
            sync2 <= sync1;
        end
    end
    assign {reset_in, nmi_in, irq_in} = sync2;
`else
    assign {reset_in, nmi_in, irq_in} = {resetReq, nmiReq, irq};
`endif
    function automatic logic [2:0] op_of(input state_t s);
        return s == PCH ? 3'd1 : s == PCL ? 3'd2 : s == FLG ? 3'd3 : s == VLO ? 3'd4 : s == VHI ? 3'd5 : 3'd0;
    endfunction
    function automatic state_t next_of(input state_t s);
        return s == PCH ? PCL : s == PCL ? FLG : s == FLG ? VLO : s == VLO ? VHI : DONE;
    endfunction
    function automatic logic [15:0] addr_of(input state_t s, input logic [1:0] t);
        logic [15:0] vec;
        vec = t == 2'd1 ? RESET_VEC : t == 2'd2 ? NMI_VEC : IRQ_VEC;
        return s == VLO ? vec : s == VHI ? vec + 16'd1 : 16'd0;
    endfunction
    // request qualification and fixed-priority winner selection
    always_comb begin
        nmi_edge = nmi_in & ~nmi_prev;
        reset_q = reset_in | por_pend;
        nmi_q = nmi_pend | nmi_edge;
        irq_q = irq_in & irqEn;
        winner = reset_q ? 2'd1 : nmi_q ? 2'd2 : irq_q ? 2'd3 : 2'd0;
        abort = (state inside {PCH, PCL, FLG, VLO, VHI}) && reset_in && intType != 2'd1;
    end
    // sequencer FSM with registered decoder-facing outputs
    always_ff @(posedge sysClock) begin
        if (sysReset) begin
            state <= IDLE;
            nmi_prev <= 1'b0;
            nmi_pend <= 1'b0;
            por_pend <= 1'b1;
            intActive <= 1'b0;
            stepReq <= 1'b0;
            stepOp <= 3'd0;
            stepAddr <= 16'd0;
            intType <= 2'd0;
            setIrqDis <= 1'b0;
        end else begin
            nmi_prev <= nmi_in;
            nmi_pend <= nmi_pend | nmi_edge;
            setIrqDis <= 1'b0;
            if (abort) begin
                state <= VLO;
                stepReq <= 1'b0;
                stepOp <= 3'd0;
                stepAddr <= 16'd0;
                intType <= 2'd1;
            end else begin
                case (state)
                    IDLE: state <= winner != 2'd0 ? ARM : IDLE;
                    ARM: begin
                        if (winner == 2'd0) begin
                            state <= IDLE;
                        end else if (instBoundary) begin
                            state <= winner == 2'd1 ? VLO : PCH;
                            intType <= winner;
                            intActive <= 1'b1;
                            stepReq <= 1'b1;
                            stepOp <= winner == 2'd1 ? 3'd4 : 3'd1;
                            stepAddr <= winner == 2'd1 ? addr_of(VLO, winner) : 16'd0;
                            if (winner == 2'd1) por_pend <= 1'b0;
                            if (winner == 2'd2) nmi_pend <= 1'b0;
                        end
                    end
                    DONE: state <= winner != 2'd0 ? ARM : IDLE;
                    default: begin
                        if (!stepReq) begin
                            stepReq <= 1'b1;
                            stepOp <= op_of(state);
                            stepAddr <= addr_of(state, intType);
                        end else if (stepDone) begin
                            state <= next_of(state);
                            stepReq <= 1'b0;
                            stepOp <= 3'd0;
                            stepAddr <= 16'd0;
                            if (state == VHI) begin
                                setIrqDis <= 1'b1;
                                intActive <= 1'b0;
                                intType <= 2'd0;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_r88_int_sequencer.sv
// tb_r88_int_sequencer: directed self-checking bench for the interrupt sequencer
module tb_r88_int_sequencer;
    logic sysClock = 1'b0;
    logic sysReset = 1'b1;
    logic resetReq = 1'b0;
    logic nmiReq = 1'b0;
    logic irq = 1'b0;
    logic irqEn = 1'b0;
    logic instBoundary = 1'b0;
    logic stepDone = 1'b0;
    logic intActive, stepReq, setIrqDis;
    logic [2:0] stepOp;
    logic [15:0] stepAddr;
    logic [1:0] intType;
    int compared = 0;
    int mismatched = 0;
    int seen;

    r88_int_sequencer dut (
        .sysClock(sysClock),
        .sysReset(sysReset),
        .resetReq(resetReq),
        .nmiReq(nmiReq),
        .irq(irq),
        .irqEn(irqEn),
        .instBoundary(instBoundary),
        .stepDone(stepDone),
        .intActive(intActive),
        .stepReq(stepReq),
        .stepOp(stepOp),
        .stepAddr(stepAddr),
        .intType(intType),
        .setIrqDis(setIrqDis)
    );

    always #5 sysClock = ~sysClock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic boundary();
        instBoundary = 1'b1;
        @(negedge sysClock);
        instBoundary = 1'b0;
    endtask

    task automatic run_step(input logic [2:0] op, input logic [15:0] addr);
        for (int i = 0; i < 16 && !stepReq; i++) @(negedge sysClock);
        check("step_req", stepReq, 1);
        check("step_active", intActive, 1);
        check("step_op", stepOp, op);
        check("step_addr", stepAddr, addr);
        stepDone = 1'b1;
        @(negedge sysClock);
        stepDone = 1'b0;
        check("step_gap", stepReq, 0);
    endtask

    task automatic done_chk();
        check("done_irqdis", setIrqDis, 1);
        check("done_active", intActive, 0);
        check("done_type", intType, 0);
    endtask

    task automatic run_seq(input logic [1:0] t);
        logic [15:0] v;
        v = t == 2'd1 ? 16'hFFFC : t == 2'd2 ? 16'hFFFA : 16'hFFFE;
        if (t != 2'd1) for (int i = 1; i <= 3; i++) run_step(3'(i), 16'h0000);
        run_step(3'd4, v);
        run_step(3'd5, v + 16'd1);
        done_chk();
        @(negedge sysClock);
        check("irqdis_pulse", setIrqDis, 0);
    endtask

    initial begin
        repeat (3) @(negedge sysClock);
        check("rst_req", stepReq, 0);
        check("rst_active", intActive, 0);
        check("rst_type", intType, 0);
        check("rst_op", stepOp, 0);
        check("rst_addr", stepAddr, 0);
        check("rst_irqdis", setIrqDis, 0);

        sysReset = 1'b0;
        @(negedge sysClock);
        check("por_arm_active", intActive, 0);
        boundary();
        check("por_latency", stepReq, 1);
        check("por_type", intType, 1);
        run_seq(2'd1);

        irq = 1'b1;
        irqEn = 1'b1;
        @(negedge sysClock);
        check("irq_arm_active", intActive, 0);
        boundary();
        check("irq_latency", stepReq, 1);
        check("irq_type", intType, 3);
        irq = 1'b0;
        run_seq(2'd3);

        irq = 1'b1;
        irqEn = 1'b0;
        seen = 0;
        instBoundary = 1'b1;
        repeat (20) begin
            @(negedge sysClock);
            seen += int'(stepReq) + int'(intActive);
        end
        instBoundary = 1'b0;
        check("masked_irq", seen, 0);
        irq = 1'b0;

        @(negedge sysClock);
        irq = 1'b1;
        irqEn = 1'b1;
        nmiReq = 1'b1;
        @(negedge sysClock);
        boundary();
        check("prio_nmi_type", intType, 2);
        run_seq(2'd2);
        boundary();
        check("prio_irq_after", intType, 3);
        irq = 1'b0;
        run_seq(2'd3);
        irqEn = 1'b0;

        nmiReq = 1'b0;
        @(negedge sysClock);
        nmiReq = 1'b1;
        @(negedge sysClock);
        boundary();
        check("nmi_edge_type", intType, 2);
        run_seq(2'd2);
        seen = 0;
        instBoundary = 1'b1;
        repeat (40) begin
            @(negedge sysClock);
            seen += int'(stepReq);
        end
        instBoundary = 1'b0;
        check("nmi_level_once", seen, 0);
        nmiReq = 1'b0;
        @(negedge sysClock);
        nmiReq = 1'b1;
        @(negedge sysClock);
        boundary();
        check("nmi_fresh_type", intType, 2);
        run_seq(2'd2);
        nmiReq = 1'b0;

        irq = 1'b1;
        irqEn = 1'b1;
        @(negedge sysClock);
        boundary();
        run_step(3'd1, 16'h0000);
        for (int i = 0; i < 16 && !stepReq; i++) @(negedge sysClock);
        check("abort_pcl_op", stepOp, 2);
        resetReq = 1'b1;
        irq = 1'b0;
        @(negedge sysClock);
        resetReq = 1'b0;
        check("abort_gap", stepReq, 0);
        check("abort_type", intType, 1);
        check("abort_active", intActive, 1);
        @(negedge sysClock);
        check("abort_req", stepReq, 1);
        run_step(3'd4, 16'hFFFC);
        run_step(3'd5, 16'hFFFD);
        done_chk();
        @(negedge sysClock);

        irq = 1'b1;
        @(negedge sysClock);
        boundary();
        check("mid_rst_pre", stepReq, 1);
        sysReset = 1'b1;
        irq = 1'b0;
        @(negedge sysClock);
        check("mid_rst_req", stepReq, 0);
        check("mid_rst_active", intActive, 0);
        check("mid_rst_type", intType, 0);
        sysReset = 1'b0;
        @(negedge sysClock);
        boundary();
        check("rearm_type", intType, 1);
        run_seq(2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
